bitwise_logic_pipe: RTL and testbench
=====================================

Name: bitwise_logic_pipe

Overview:
- Parametrised, pipelined successor to the 32-bit structural AND block in the MIPS ALU datapath.
- Performs one of eight bitwise/logical operations on two WIDTH-bit operands.
- Two register stages with a valid/ready handshake on each side; full backpressure at one result per cycle.
- Also produces a zero flag and a saturating count of completed operations for ALU status and debug.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept an operand beat.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  3  operation select (encodings in logic_pkg).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_y  out  WIDTH  result.
- out_zero  out  1  out_y == 0.
- op_count  out  CNT_W  saturating count of results accepted downstream.

Behaviour:
- Op encodings:
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 NOR
  - 100 ANDN (a & ~b)
  - 101 RAND: reduction-AND of (a & b) in bit 0, upper bits 0
  - 110 PASSA
  - 111 PASSB
- All encodings are legal; there is no error path.
- Stage 1 (s1) registers a, b, op and s1_valid. Stage 2 computes the op from the s1 registers and registers out_y, out_zero and out_valid.
- Advance rules:
  - s2_load = s1_valid && (!out_valid || out_ready).
  - s1 accepts when in_valid && in_ready.
  - in_ready = !s1_valid || s2_load. This is combinational from out_valid/out_ready; there is no skid buffer.
- Validity updates:
  - s1_valid next = accept ? 1 : (s2_load ? 0 : s1_valid).
  - out_valid next = s2_load ? 1 : ((out_valid && out_ready) ? 0 : out_valid).
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+1, i.e. two cycles from in_valid to out_valid, with no bubbles under continuous flow.
- Throughput is 1 beat/cycle while out_ready=1.
- Stability: while out_valid && !out_ready, out_y and out_zero hold unchanged. s1 holds its contents; in_ready=0 once s1 is full.
- Simultaneous events in the same cycle (s1 loading from the input, s1 draining into s2, and s2 draining downstream) are all legal. No beat is lost or duplicated.
- out_zero is registered with out_y; it is never computed from a stale result.
- op_count:
  - Increments by 1 on each out_valid && out_ready.
  - Saturates at 2^CNT_W-1 and does not wrap.
- Reset: asynchronous assertion clears s1_valid, out_valid, out_y, out_zero and op_count to 0, so in_ready=1 after reset. Any in-flight beats are discarded. Deassertion takes effect on the next edge.
- Operand registers need no reset for function, but they are reset to 0 for deterministic simulation.

Decomposition:
- logic_pkg:
  - localparam op encodings: OP_AND, OP_OR, OP_XOR, OP_NOR, OP_ANDN, OP_RAND, OP_PASSA, OP_PASSB.
  - OP_W = 3.
- Sub-module bitwise_logic_core (WIDTH): purely combinational a/b/op -> y, instantiated in stage 2. This keeps the pipeline/handshake logic separate from the function logic so that it can be reused by the ALU top.

Test Plan:
- Reset: assert rst mid-stream with two beats in flight -> out_valid=0, in_ready=1, op_count=0 immediately. Those beats never appear after rst is released.
- Op sweep, WIDTH=32, a=0xF0F0_1234, b=0x0FF0_FFFF, one beat per op with out_ready=1. Required results, each 2 cycles after acceptance:
  - AND 0x00F0_1234
  - OR 0xFFF0_FFFF
  - XOR 0xFF00_EDCB
  - NOR 0x000F_0000
  - ANDN 0xF000_0000
  - RAND 0x0000_0000
  - PASSA 0xF0F0_1234
  - PASSB 0x0FF0_FFFF
- Zero/reduction: AND a=0xFFFF_0000, b=0x0000_FFFF -> out_y=0, out_zero=1. RAND a=b=0xFFFF_FFFF -> out_y=0x1, out_zero=0.
- Backpressure: stream 5 AND beats with out_ready=0 for 4 cycles, then 1:
  - in_ready drops after 2 beats are accepted.
  - out_y holds the first result stable.
  - All 5 results emerge in order, no loss or duplication.
  - op_count=5.
- Saturation: CNT_W=3, 10 beats accepted downstream -> op_count stops at 7.
- Width: WIDTH=8, a=0xA5, b=0x3C, XOR -> 0x99. Random back-to-back traffic checked against a reference model with 1-cycle out_ready toggling.

Source files
------------

// File: rtl/logic_pkg.sv
// Shared definitions for the bitwise logic pipeline: operation select width
// and the eight operation encodings understood by bitwise_logic_core.
package logic_pkg;

    localparam int OP_W = 3;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_AND   = 3'b000;
    localparam op_t OP_OR    = 3'b001;
    localparam op_t OP_XOR   = 3'b010;
    localparam op_t OP_NOR   = 3'b011;
    localparam op_t OP_ANDN  = 3'b100;
    localparam op_t OP_RAND  = 3'b101;
    localparam op_t OP_PASSA = 3'b110;
    localparam op_t OP_PASSB = 3'b111;

endpackage

// File: rtl/bitwise_logic_core.sv
// Purely combinational function unit: applies one of the eight bitwise
// operations to a and b. Holds no state so the ALU top can reuse it directly.
module bitwise_logic_core
    import logic_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  op_t              op_i,
    output logic [WIDTH-1:0] y_o
);

    always_comb begin
        y_o = '0;
        case (op_i)
            OP_AND:   y_o = a_i & b_i;
            OP_OR:    y_o = a_i | b_i;
            OP_XOR:   y_o = a_i ^ b_i;
            OP_NOR:   y_o = ~(a_i | b_i);
            OP_ANDN:  y_o = a_i & ~b_i;
            // Reduction result lives in bit 0 only; the upper bits stay zero.
            OP_RAND:  y_o[0] = &(a_i & b_i);
            OP_PASSA: y_o = a_i;
            OP_PASSB: y_o = b_i;
            default:  y_o = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_pipe.sv
// Two-stage pipelined bitwise unit with valid/ready on both sides: s1 holds
// the operands, s2 holds the registered result, zero flag and op counter.
module bitwise_logic_pipe
    import logic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  op_t              in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] s1A_q, s1A_d;
    logic [WIDTH-1:0] s1B_q, s1B_d;
    op_t              s1Op_q, s1Op_d;
    logic             s1Valid_q, s1Valid_d;

    logic [WIDTH-1:0] outY_q, outY_d;
    logic             outZero_q, outZero_d;
    logic             outValid_q, outValid_d;
    logic [CNT_W-1:0] opCount_q, opCount_d;

    logic             s2Load;
    logic             accept;
    logic             outFire;
    logic [WIDTH-1:0] coreY;

    bitwise_logic_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i  (s1A_q),
        .b_i  (s1B_q),
        .op_i (s1Op_q),
        .y_o  (coreY)
    );

    // No skid buffer: in_ready depends combinationally on out_ready via s2Load.
    always_comb begin
        s2Load   = s1Valid_q && (!outValid_q || out_ready);
        in_ready = !s1Valid_q || s2Load;
        accept   = in_valid && in_ready;
        outFire  = outValid_q && out_ready;
    end

    always_comb begin
        s1A_d     = s1A_q;
        s1B_d     = s1B_q;
        s1Op_d    = s1Op_q;
        s1Valid_d = s1Valid_q;
        if (accept) begin
            s1A_d     = in_a;
            s1B_d     = in_b;
            s1Op_d    = in_op;
            s1Valid_d = 1'b1;
        end else if (s2Load) begin
            s1Valid_d = 1'b0;
        end
    end

    // Zero flag is captured alongside the result so it can never lag it.
    always_comb begin
        outY_d     = outY_q;
        outZero_d  = outZero_q;
        outValid_d = outValid_q;
        if (s2Load) begin
            outY_d     = coreY;
            outZero_d  = (coreY == '0);
            outValid_d = 1'b1;
        end else if (outFire) begin
            outValid_d = 1'b0;
        end
    end

    always_comb begin
        opCount_d = opCount_q;
        if (outFire && (opCount_q != CNT_MAX)) begin
            opCount_d = opCount_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1A_q     <= '0;
            s1B_q     <= '0;
            s1Op_q    <= OP_AND;
            s1Valid_q <= 1'b0;
        end else begin
            s1A_q     <= s1A_d;
            s1B_q     <= s1B_d;
            s1Op_q    <= s1Op_d;
            s1Valid_q <= s1Valid_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outY_q     <= '0;
            outZero_q  <= 1'b0;
            outValid_q <= 1'b0;
            opCount_q  <= '0;
        end else begin
            outY_q     <= outY_d;
            outZero_q  <= outZero_d;
            outValid_q <= outValid_d;
            opCount_q  <= opCount_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_y     = outY_q;
    assign out_zero  = outZero_q;
    assign op_count  = opCount_q;

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Bench for bitwise_logic_pipe: a 32-bit/16-bit-counter instance and an
// 8-bit/3-bit-counter instance, each scored against a queue-based model.
module tb_bitwise_logic_pipe;
    import logic_pkg::*;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        inValid32, inReady32, outValid32, outReady32, outZero32;
    logic [31:0] inA32, inB32, outY32;
    logic [2:0]  inOp32;
    logic [15:0] opCount32;

    logic        inValid8, inReady8, outValid8, outReady8, outZero8;
    logic [7:0]  inA8, inB8, outY8;
    logic [2:0]  inOp8;
    logic [2:0]  opCount8;

    int nChecks = 0;
    int nFails  = 0;

    bitwise_logic_pipe #(.WIDTH(32), .CNT_W(16)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(inValid32), .in_ready(inReady32),
        .in_a(inA32), .in_b(inB32), .in_op(inOp32),
        .out_valid(outValid32), .out_ready(outReady32),
        .out_y(outY32), .out_zero(outZero32), .op_count(opCount32)
    );

    bitwise_logic_pipe #(.WIDTH(8), .CNT_W(3)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(inValid8), .in_ready(inReady8),
        .in_a(inA8), .in_b(inB8), .in_op(inOp8),
        .out_valid(outValid8), .out_ready(outReady8),
        .out_y(outY8), .out_zero(outZero8), .op_count(opCount8)
    );

    // Reference semantics of each operation, masked to the operand width.
    function automatic logic [31:0] refOp(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op, input int width);
        logic [31:0] mask;
        logic [31:0] r;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = a ^ b;
            3'd3:    r = ~(a | b);
            3'd4:    r = a & ~b;
            3'd5:    r = (((a & b) & mask) == mask) ? 32'd1 : 32'd0;
            3'd6:    r = a;
            default: r = b;
        endcase
        return r & mask;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit narrow, input logic v, input logic [31:0] a,
                                 input logic [31:0] b, input logic [2:0] op);
        if (narrow) begin
            inValid8 = v;
            inA8     = a[7:0];
            inB8     = b[7:0];
            inOp8    = op;
        end else begin
            inValid32 = v;
            inA32     = a;
            inB32     = b;
            inOp32    = op;
        end
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    // Scoreboards hold {zero, y} of every accepted beat in acceptance order.
    logic [32:0] q32[$];
    logic [32:0] q8[$];
    int          modelCount32;
    int          modelCount8;
    logic [31:0] mY32, mY8;

    always @(negedge clk) begin
        if (rst) begin
            q32.delete();
            modelCount32 = 0;
        end else begin
            checkOutput("count32", {16'd0, opCount32}, modelCount32);
            if (outValid32) begin
                if (q32.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL ghost32: got result 0x%0h, required no result", outY32);
                end else begin
                    checkOutput("y32", outY32, q32[0][31:0]);
                    checkOutput("zero32", {31'd0, outZero32}, {31'd0, q32[0][32]});
                    if (outReady32) begin
                        void'(q32.pop_front());
                        if (modelCount32 < 65535) modelCount32++;
                    end
                end
            end
            if (inValid32 && inReady32) begin
                mY32 = refOp(inA32, inB32, inOp32, 32);
                q32.push_back({(mY32 == 32'd0), mY32});
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q8.delete();
            modelCount8 = 0;
        end else begin
            checkOutput("count8", {29'd0, opCount8}, modelCount8);
            if (outValid8) begin
                if (q8.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL ghost8: got result 0x%0h, required no result", outY8);
                end else begin
                    checkOutput("y8", {24'd0, outY8}, q8[0][31:0]);
                    checkOutput("zero8", {31'd0, outZero8}, {31'd0, q8[0][32]});
                    if (outReady8) begin
                        void'(q8.pop_front());
                        if (modelCount8 < 7) modelCount8++;
                    end
                end
            end
            if (inValid8 && inReady8) begin
                mY8 = refOp({24'd0, inA8}, {24'd0, inB8}, inOp8, 8);
                q8.push_back({(mY8 == 32'd0), mY8});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [31:0] sweepExp[8];
    logic [31:0] bpA[5];
    logic [31:0] bpB[5];

    initial begin
        int accepted;
        int received;
        bit sawDrop;

        rst = 1'b1;
        applyStimulus(0, 1'b0, 32'd0, 32'd0, OP_AND);
        applyStimulus(1, 1'b0, 32'd0, 32'd0, OP_AND);
        outReady32 = 1'b1;
        outReady8  = 1'b1;
        sweepExp = '{32'h00F0_1234, 32'hFFF0_FFFF, 32'hFF00_EDCB, 32'h000F_0000,
                     32'hF000_0000, 32'h0000_0000, 32'hF0F0_1234, 32'h0FF0_FFFF};

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", {31'd0, inReady32}, 32'd1);
        checkOutput("rst_out_valid", {31'd0, outValid32}, 32'd0);
        checkOutput("rst_out_zero", {31'd0, outZero32}, 32'd0);
        checkOutput("rst_op_count", {16'd0, opCount32}, 32'd0);
        nextCycle;
        rst = 1'b0;
        nextCycle;

        for (int k = 0; k < 8; k++)
            checkOutput($sformatf("model_op%0d", k), refOp(32'hF0F0_1234, 32'h0FF0_FFFF, 3'(k), 32), sweepExp[k]);

        // Back-to-back op sweep: beat t is visible at the negedge two cycles later.
        for (int t = 0; t < 10; t++) begin
            if (t < 8) applyStimulus(0, 1'b1, 32'hF0F0_1234, 32'h0FF0_FFFF, 3'(t));
            else       applyStimulus(0, 1'b0, 32'd0, 32'd0, OP_AND);
            @(negedge clk);
            if (t >= 2) begin
                checkOutput("sweep_valid", {31'd0, outValid32}, 32'd1);
                checkOutput($sformatf("sweep_op%0d", t - 2), outY32, sweepExp[t - 2]);
            end
            nextCycle;
        end

        for (int t = 0; t < 4; t++) begin
            if (t == 0)      applyStimulus(0, 1'b1, 32'hFFFF_0000, 32'h0000_FFFF, OP_AND);
            else if (t == 1) applyStimulus(0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_RAND);
            else             applyStimulus(0, 1'b0, 32'd0, 32'd0, OP_AND);
            @(negedge clk);
            if (t == 2) begin
                checkOutput("zero_and_y", outY32, 32'd0);
                checkOutput("zero_and_flag", {31'd0, outZero32}, 32'd1);
            end else if (t == 3) begin
                checkOutput("rand_y", outY32, 32'd1);
                checkOutput("rand_flag", {31'd0, outZero32}, 32'd0);
            end
            nextCycle;
        end

        // Mid-stream reset with one beat in s1 and one stalled in s2.
        outReady32 = 1'b0;
        applyStimulus(0, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF, OP_PASSA);
        nextCycle;
        applyStimulus(0, 1'b1, 32'hCAFE_0000, 32'h0000_BEEF, OP_OR);
        nextCycle;
        applyStimulus(0, 1'b0, 32'd0, 32'd0, OP_AND);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", {31'd0, outValid32}, 32'd0);
        checkOutput("midrst_in_ready", {31'd0, inReady32}, 32'd1);
        checkOutput("midrst_op_count", {16'd0, opCount32}, 32'd0);
        @(negedge clk);
        nextCycle;
        rst = 1'b0;
        outReady32 = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            checkOutput("postrst_no_ghost", {31'd0, outValid32}, 32'd0);
            nextCycle;
        end

        // Backpressure: downstream stalls for four cycles while five ANDs stream in.
        for (int k = 0; k < 5; k++) begin
            bpA[k] = $urandom;
            bpB[k] = $urandom;
        end
        accepted = 0;
        received = 0;
        sawDrop  = 1'b0;
        for (int cyc = 0; cyc < 40 && received < 5; cyc++) begin
            outReady32 = (cyc >= 4);
            applyStimulus(0, accepted < 5, bpA[(accepted < 5) ? accepted : 0],
                          bpB[(accepted < 5) ? accepted : 0], OP_AND);
            @(negedge clk);
            if (accepted == 2 && !outReady32 && !sawDrop) begin
                checkOutput("bp_in_ready_drop", {31'd0, inReady32}, 32'd0);
                sawDrop = 1'b1;
            end
            if (outValid32 && !outReady32)
                checkOutput("bp_hold", outY32, bpA[0] & bpB[0]);
            if (outValid32 && outReady32 && received < 5) begin
                checkOutput($sformatf("bp_order%0d", received), outY32, bpA[received] & bpB[received]);
                received++;
            end
            if (inValid32 && inReady32) accepted++;
            nextCycle;
        end
        applyStimulus(0, 1'b0, 32'd0, 32'd0, OP_AND);
        @(negedge clk);
        checkOutput("bp_received", received, 32'd5);
        checkOutput("bp_saw_drop", {31'd0, sawDrop}, 32'd1);
        checkOutput("bp_op_count", {16'd0, opCount32}, 32'd5);
        nextCycle;

        // Narrow instance: width check, then drive the 3-bit counter into saturation.
        for (int t = 0; t < 3; t++) begin
            if (t == 0) applyStimulus(1, 1'b1, 32'hA5, 32'h3C, OP_XOR);
            else        applyStimulus(1, 1'b0, 32'd0, 32'd0, OP_AND);
            @(negedge clk);
            if (t == 2) checkOutput("w8_xor", {24'd0, outY8}, 32'h99);
            nextCycle;
        end
        for (int t = 0; t < 14; t++) begin
            applyStimulus(1, t < 10, $urandom, $urandom, 3'($urandom_range(0, 7)));
            @(negedge clk);
            nextCycle;
        end
        @(negedge clk);
        checkOutput("sat_count", {29'd0, opCount8}, 32'd7);
        nextCycle;

        // Random traffic on both instances; narrow side toggles out_ready each cycle.
        for (int cyc = 0; cyc < 400; cyc++) begin
            applyStimulus(0, $urandom_range(0, 3) != 0, $urandom, $urandom, 3'($urandom_range(0, 7)));
            applyStimulus(1, $urandom_range(0, 3) != 0, $urandom, $urandom, 3'($urandom_range(0, 7)));
            outReady32 = ($urandom_range(0, 2) != 0);
            outReady8  = cyc[0];
            nextCycle;
        end
        applyStimulus(0, 1'b0, 32'd0, 32'd0, OP_AND);
        applyStimulus(1, 1'b0, 32'd0, 32'd0, OP_AND);
        outReady32 = 1'b1;
        outReady8  = 1'b1;
        repeat (5) nextCycle;
        @(negedge clk);
        checkOutput("drain32", q32.size(), 32'd0);
        checkOutput("drain8", q8.size(), 32'd0);
        checkOutput("final_sat8", {29'd0, opCount8}, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule
